// File: rtl/reg_mem_sequencer_pkg.sv
// Shared encodings for the register-file memory sequencer: command opcodes,
// FSM state codes and a small opcode helper.
package reg_mem_seq_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD  = 2'b00;
  localparam op_t OP_STORE = 2'b01;
  localparam op_t OP_PUSH  = 2'b10;
  localparam op_t OP_POP   = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_PRE    = 3'd1;
  localparam state_t ST_ACCESS = 3'd2;
  localparam state_t ST_POST   = 3'd3;
  localparam state_t ST_ABORT  = 3'd4;

  // STORE and PUSH move a register to memory; LOAD and POP move memory to a register.
  function automatic logic op_writes(input op_t op);
    return (op == OP_STORE) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/reg_mem_sequencer_if.sv
// Command and memory-bus signals between decode, the sequencer and memory.
// The master side is decode plus memory; the slave side is the sequencer.
interface reg_mem_sequencer_if #(
  parameter int REG_BITS = 3
) ();

  // Handshakes: a command transfers on a cycle where cmd_valid and cmd_ready
  // are both high, and cmd_op/cmd_rd/cmd_ra must be stable while cmd_valid is
  // high. A memory access is open while mem_req is high and completes on the
  // cycle mem_ack is high; mem_ack outside an open access is ignored.
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [REG_BITS-1:0] cmd_rd;
  logic [REG_BITS-1:0] cmd_ra;
  logic                mem_req;
  logic                mem_wr;
  logic                mem_ack;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, mem_ack,
    input  cmd_ready, mem_req, mem_wr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, mem_ack,
    output cmd_ready, mem_req, mem_wr
  );

endinterface

// File: rtl/reg_mem_sequencer_decoder.sv
// Register-index to active-low one-hot strobe decoder; all ones when disabled.
module onehot_lowb_decoder #(
  parameter int SEL_BITS = 3
) (
  input  logic [SEL_BITS-1:0]      sel_i,
  input  logic                     en_i,
  output logic [(2**SEL_BITS)-1:0] out_o
);

  always_comb begin
    out_o = '1;
    if (en_i) begin
      out_o[sel_i] = 1'b0;
    end
  end

endmodule

// File: rtl/reg_mem_sequencer.sv
// Load/store/push/pop sequencer owning the register file's memory-side controls.
// Optional ack watchdog with ABORT state: define REG_MEM_SEQ_TIMEOUT_EN.
module reg_mem_sequencer
  import reg_mem_seq_pkg::*;
#(
  parameter int REG_BITS       = 3,
  parameter int BITS           = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  reg_mem_sequencer_if.slave       bus,
  output logic [(2**REG_BITS)-1:0] LD_reg_Mb,
  output logic                     M_ENb,
  output logic [REG_BITS-1:0]      M_SEL,
  output logic [REG_BITS-1:0]      MADDR_SEL,
  output logic [(2**REG_BITS)-1:0] INCb,
  output logic [(2**REG_BITS)-1:0] DECb,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output state_t                   dbg_state_o
);

  // BITS only has to match the register file; the watchdog limit must fit 8 bits.
  if (BITS < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("reg_mem_sequencer: BITS must be >= 1 and TIMEOUT_CYCLES in 1..255");
  end

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic [REG_BITS-1:0] ra_q, ra_d;
  logic                done_q, done_d;

`ifdef REG_MEM_SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]          cnt_q, cnt_d;
`endif

  logic in_access;
  logic wr_access;
  logic ld_en;
  logic inc_en;
  logic dec_en;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    done_d  = 1'b0;
`ifdef REG_MEM_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          rd_d    = bus.cmd_rd;
          ra_d    = bus.cmd_ra;
          state_d = (bus.cmd_op == OP_PUSH) ? ST_PRE : ST_ACCESS;
`ifdef REG_MEM_SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_PRE: begin
        state_d = ST_ACCESS;
`ifdef REG_MEM_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_ACCESS: begin
        // A POP into its own stack pointer skips the increment so the loaded value wins.
        if (bus.mem_ack) begin
          if (op_q == OP_POP && rd_q != ra_q) begin
            state_d = ST_POST;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
`ifdef REG_MEM_SEQ_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_POST: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
`ifdef REG_MEM_SEQ_TIMEOUT_EN
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      rd_q    <= '0;
      ra_q    <= '0;
      done_q  <= 1'b0;
`ifdef REG_MEM_SEQ_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      done_q  <= done_d;
`ifdef REG_MEM_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Everything except the load strobe is decoded from registered state, so an
  // asynchronous reset drops mem_req immediately.
  always_comb begin
    in_access     = (state_q == ST_ACCESS);
    wr_access     = in_access && op_writes(op_q);
    ld_en         = in_access && !op_writes(op_q) && bus.mem_ack;
    dec_en        = (state_q == ST_PRE);
`ifdef REG_MEM_SEQ_TIMEOUT_EN
    inc_en        = (state_q == ST_POST) || (state_q == ST_ABORT && op_q == OP_PUSH);
    err           = (state_q == ST_ABORT);
`else
    inc_en        = (state_q == ST_POST);
    err           = 1'b0;
`endif
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.mem_req   = in_access;
    bus.mem_wr    = wr_access;
    busy          = (state_q != ST_IDLE);
    done          = done_q;
    M_ENb         = !wr_access;
    M_SEL         = wr_access ? rd_q : '0;
    MADDR_SEL     = in_access ? ra_q : '0;
    dbg_state_o   = state_q;
  end

  onehot_lowb_decoder #(.SEL_BITS(REG_BITS)) u_ld_dec (
    .sel_i (rd_q),
    .en_i  (ld_en),
    .out_o (LD_reg_Mb)
  );

  onehot_lowb_decoder #(.SEL_BITS(REG_BITS)) u_inc_dec (
    .sel_i (ra_q),
    .en_i  (inc_en),
    .out_o (INCb)
  );

  onehot_lowb_decoder #(.SEL_BITS(REG_BITS)) u_dec_dec (
    .sel_i (ra_q),
    .en_i  (dec_en),
    .out_o (DECb)
  );

endmodule

// File: tb/tb_reg_mem_sequencer.sv
// Scoreboard bench for reg_mem_sequencer: per-command expected summaries are
// queued at issue time and compared by a monitor when done pulses.
module tb_reg_mem_sequencer;
  import reg_mem_seq_pkg::*;

  localparam int RB = 3;
  localparam int NR = 8;

  logic          CLK = 1'b0;
  logic          RSTb = 1'b0;
  logic [NR-1:0] LD_reg_Mb, INCb, DECb;
  logic          M_ENb;
  logic [RB-1:0] M_SEL, MADDR_SEL;
  logic          busy, done, err;
  state_t        dbg_state;

  reg_mem_sequencer_if #(.REG_BITS(RB)) bus ();

  reg_mem_sequencer #(.REG_BITS(RB), .BITS(16), .TIMEOUT_CYCLES(255)) dut (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .bus         (bus),
    .LD_reg_Mb   (LD_reg_Mb),
    .M_ENb       (M_ENb),
    .M_SEL       (M_SEL),
    .MADDR_SEL   (MADDR_SEL),
    .INCb        (INCb),
    .DECb        (DECb),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [15:0] lat;
    logic [7:0]  req_cyc;
    logic        wr;
    logic [2:0]  addr;
    logic [2:0]  msel;
    logic [7:0]  menb_cyc;
    logic [7:0]  ld_mask;
    logic [7:0]  ld_cyc;
    logic [7:0]  dec_mask;
    logic [7:0]  dec_cyc;
    logic [7:0]  inc_mask;
    logic [7:0]  inc_cyc;
  } resp_t;
  localparam int RESP_W = $bits(resp_t);

  logic [RESP_W-1:0] exp_q[$];
  int                delay_q[$];
  int                vectors = 0;
  int                miscompares = 0;

  localparam logic [36:0] RST_EXP = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     8'hFF, 8'hFF, 8'hFF, 1'b1, 3'd0, 3'd0};

  function automatic logic [36:0] outs();
    return {bus.cmd_ready, busy, done, err, bus.mem_req, bus.mem_wr,
            LD_reg_Mb, INCb, DECb, M_ENb, M_SEL, MADDR_SEL};
  endfunction

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: what one command should look like from outside, from the
  // command's rules and the memory's ack delay.
  function automatic resp_t model(input op_t op, input logic [2:0] rd,
                                  input logic [2:0] ra, input int delay);
    resp_t r;
    bit    rdop, wrop, post;
    r    = '0;
    wrop = (op == OP_STORE) || (op == OP_PUSH);
    rdop = !wrop;
    post = (op == OP_POP) && (rd != ra);
    r.lat      = 16'(2 + delay + ((op == OP_PUSH) ? 1 : 0) + (post ? 1 : 0));
    r.req_cyc  = 8'(delay + 1);
    r.wr       = wrop;
    r.addr     = ra;
    r.msel     = wrop ? rd : 3'd0;
    r.menb_cyc = wrop ? 8'(delay + 1) : 8'd0;
    r.ld_mask  = rdop ? (8'd1 << rd) : 8'd0;
    r.ld_cyc   = rdop ? 8'd1 : 8'd0;
    r.dec_mask = (op == OP_PUSH) ? (8'd1 << ra) : 8'd0;
    r.dec_cyc  = (op == OP_PUSH) ? 8'd1 : 8'd0;
    r.inc_mask = post ? (8'd1 << ra) : 8'd0;
    r.inc_cyc  = post ? 8'd1 : 8'd0;
    return r;
  endfunction

  // ---------------- memory responder ----------------
  int ack_wait = 0;
  always @(posedge CLK) begin
    #1;
    if (!RSTb) begin
      bus.mem_ack = 1'b0;
      ack_wait    = 0;
    end else if (bus.mem_req) begin
      if (delay_q.size() > 0 && ack_wait == delay_q[0]) begin
        bus.mem_ack = 1'b1;
        void'(delay_q.pop_front());
        ack_wait = 0;
      end else begin
        bus.mem_ack = 1'b0;
        ack_wait++;
      end
    end else begin
      // Spurious acks outside an access must have no effect.
      bus.mem_ack = 1'($urandom_range(0, 1));
      ack_wait    = 0;
    end
  end

  // ---------------- monitor ----------------
  resp_t acc;
  int    cyc = 0;
  bit    in_cmd = 0;

  always @(negedge CLK) begin
    if (!RSTb) begin
      in_cmd = 0;
    end else begin
      check("err_low", err, 0);
      check("busy_vs_ready", busy, !bus.cmd_ready);
      if (LD_reg_Mb != '1) check("ld_needs_ack", bus.mem_ack, 1);
      if (in_cmd) begin
        cyc++;
        if (bus.mem_req) acc.req_cyc += 8'd1;
        acc.wr   |= bus.mem_wr;
        acc.addr |= MADDR_SEL;
        acc.msel |= M_SEL;
        if (!M_ENb) acc.menb_cyc += 8'd1;
        if (LD_reg_Mb != '1) begin acc.ld_mask |= ~LD_reg_Mb; acc.ld_cyc += 8'd1; end
        if (DECb != '1) begin acc.dec_mask |= ~DECb; acc.dec_cyc += 8'd1; end
        if (INCb != '1) begin acc.inc_mask |= ~INCb; acc.inc_cyc += 8'd1; end
      end
      if (done) begin
        if (in_cmd && exp_q.size() > 0) begin
          acc.lat = 16'(cyc);
          check("cmd_resp", acc, exp_q.pop_front());
        end else begin
          check("stray_done", done, 0);
        end
        in_cmd = 0;
      end else if (in_cmd && cyc > 200) begin
        check("done_timeout", 1, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        in_cmd = 0;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        in_cmd = 1;
        cyc    = 0;
        acc    = '0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input op_t op, input logic [2:0] rd, input logic [2:0] ra,
                       input int delay, input bit scored);
    int n;
    if (scored) exp_q.push_back(model(op, rd, ra, delay));
    delay_q.push_back(delay);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_ra    = ra;
    n = 0;
    forever begin
      @(negedge CLK);
      if (bus.cmd_ready) break;
      n++;
      if (n > 400) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom_range(0, 3));
    bus.cmd_rd    = 3'($urandom_range(0, 7));
    bus.cmd_ra    = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge CLK);
      n++;
    end
    if (exp_q.size() > 0) check("drain_pending", exp_q.size(), 0);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    op_t        op;
    logic [2:0] rd, ra;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_rd    = '0;
    bus.cmd_ra    = '0;
    RSTb          = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTb = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("reset_outs", outs(), RST_EXP);
    end
    @(posedge CLK);
    #1;

    issue(OP_LOAD,  3'd2, 3'd5, 0, 1);
    issue(OP_STORE, 3'd1, 3'd3, 3, 1);
    issue(OP_PUSH,  3'd4, 3'd7, 0, 1);
    issue(OP_POP,   3'd4, 3'd7, 0, 1);
    issue(OP_POP,   3'd6, 3'd6, 0, 1);
    issue(OP_LOAD,  3'd0, 3'd1, 1, 1);
    issue(OP_PUSH,  3'd3, 3'd3, 2, 1);

    for (int i = 0; i < 60; i++) begin
      op = op_t'($urandom_range(0, 3));
      rd = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? rd : 3'($urandom_range(0, 7));
      issue(op, rd, ra, $urandom_range(0, 4), 1);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
    drain();

    // Reset in the middle of an access.
    issue(OP_STORE, 3'd1, 3'd3, 1000, 0);
    @(negedge CLK);
    check("req_before_reset", bus.mem_req, 1);
    #2 RSTb = 1'b0;
    #1;
    check("req_async_drop", bus.mem_req, 0);
    check("outs_in_reset", outs(), RST_EXP);
    delay_q.delete();
    @(negedge CLK);
    #1 RSTb = 1'b1;
    @(negedge CLK);
    check("outs_after_reset", outs(), RST_EXP);
    @(posedge CLK);
    #1;
    issue(OP_POP, 3'd2, 3'd5, 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
